// File: rtl/uart_pkg.sv
// Shared UART framing definitions for the rx parser and tx builder.
// SOF marker, default payload limit and frame FSM encoding.
package uart_pkg;

  localparam logic [7:0] SOF_BYTE    = 8'hA5;
  localparam int         MAX_LEN_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN,
    GET_PAY,
    GET_CHK,
    HOLD
  } frameState_t;

  function automatic logic lenOk(
    input logic [7:0] len,
    input int         maxLen
  );
    return (len != 8'd0) && (int'(len) <= maxLen);
  endfunction

endpackage

// File: rtl/rx_frame_ram.sv
// 16x8 payload store: synchronous write, registered read.
// The array itself is never reset; only the read register is.
module rx_frame_ram (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] wAddr,
  input  logic [7:0] wData,
  input  logic [3:0] rAddr,
  output logic [7:0] rData
);

  logic [7:0] mem [16];

  always_ff @(posedge clk) begin
    if (we) mem[wAddr] <= wData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rData <= 8'h00;
    else      rData <= mem[rAddr];
  end

endmodule

// File: rtl/rx_frame_parser.sv
// UART frame parser: SOF, LEN, payload, XOR checksum.
// Holds one validated frame until acknowledged.
module rx_frame_parser
  import uart_pkg::*;
#(
  parameter int MAX_LEN        = MAX_LEN_DEF,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       frame_ready,
  output logic [4:0] frame_len,
  input  logic       frame_ack,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  frameState_t state, stateNxt;

  logic [4:0]    lenReg;
  logic [7:0]    chk;
  logic [3:0]    idx;
  logic [CW-1:0] toCnt;

  logic active, expire, lenGood, lastPay, wrEn;
  logic errChkD, errLenD, errToD, errOvrD;

  assign active  = (state == GET_LEN) ||
                   (state == GET_PAY) ||
                   (state == GET_CHK);
  // rx_valid beats an expiring counter in the same cycle
  assign expire  = active && !rx_valid &&
                   (toCnt == CW'(TIMEOUT_CYCLES - 1));
  assign lenGood = lenOk(rx_data, MAX_LEN);
  assign lastPay = (({1'b0, idx} + 5'd1) == lenReg);
  assign wrEn    = (state == GET_PAY) && rx_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    if (expire) begin
      stateNxt = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (rx_valid && rx_data == SOF_BYTE)
            stateNxt = GET_LEN;
        GET_LEN:
          if (rx_valid)
            stateNxt = lenGood ? GET_PAY : IDLE;
        GET_PAY:
          if (rx_valid && lastPay)
            stateNxt = GET_CHK;
        GET_CHK:
          if (rx_valid)
            stateNxt = (rx_data == chk) ? HOLD : IDLE;
        HOLD:
          if (frame_ack)
            stateNxt = (rx_valid && rx_data == SOF_BYTE)
                     ? GET_LEN : IDLE;
        default:
          stateNxt = IDLE;
      endcase
    end
  end

  always_comb begin
    errChkD = (state == GET_CHK) && rx_valid && (rx_data != chk);
    errLenD = (state == GET_LEN) && rx_valid && !lenGood;
    errToD  = expire;
    errOvrD = (state == HOLD) && rx_valid && !frame_ack;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_chk     <= errChkD;
      err_len     <= errLenD;
      err_timeout <= errToD;
      err_overrun <= errOvrD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lenReg <= '0;
      chk    <= '0;
      idx    <= '0;
      toCnt  <= '0;
    end else begin
      if (state == GET_LEN && rx_valid && lenGood) begin
        lenReg <= rx_data[4:0];
        chk    <= rx_data;
        idx    <= '0;
      end else if (wrEn) begin
        chk <= chk ^ rx_data;
        idx <= idx + 4'd1;
      end
      if (!active || rx_valid || expire) toCnt <= '0;
      else                               toCnt <= toCnt + CW'(1);
    end
  end

  assign frame_ready = (state == HOLD);
  assign frame_len   = lenReg;

  rx_frame_ram uRam (
    .clk   (clk),
    .rst   (rst),
    .we    (wrEn),
    .wAddr (idx),
    .wData (rx_data),
    .rAddr (rd_addr),
    .rData (rd_data)
  );

endmodule

// File: tb/tb_rx_frame_parser.sv
// Self-checking bench for rx_frame_parser: frame vector table,
// held-frame scoreboard and multi-cycle corner sequences.
module tb_rx_frame_parser;
  import uart_pkg::*;

  localparam int TO = 25000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       frame_ack = 1'b0;
  logic [3:0] rd_addr = 4'h0;
  logic       frame_ready;
  logic [4:0] frame_len;
  logic [7:0] rd_data;
  logic       err_chk, err_len, err_timeout, err_overrun;

  rx_frame_parser #(.MAX_LEN(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_ready (frame_ready),
    .frame_len   (frame_len),
    .frame_ack   (frame_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .err_chk     (err_chk),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           n;
    logic [159:0] b;
    bit           good;
    int           plen;
    logic [3:0]   expErr;
  } vec_t;

  typedef struct {
    int         len;
    logic [7:0] d [16];
  } exp_t;

  exp_t sbQ[$];
  vec_t vecs[8];

  int nChecks = 0;
  int nFail   = 0;
  int cntChk = 0, cntLen = 0, cntTo = 0, cntOvr = 0;
  int pulseViol = 0;
  logic [3:0] prevErr = 4'h0;

  // error pulse monitor: counts pulses, flags wide or overlapping ones
  always @(negedge clk) begin
    logic [3:0] e;
    e = {err_overrun, err_timeout, err_len, err_chk};
    if (rst) begin
      cntChk += int'(err_chk);
      cntLen += int'(err_len);
      cntTo  += int'(err_timeout);
      cntOvr += int'(err_overrun);
      if ($countones(e) > 1) pulseViol++;
      if ((e & prevErr) != 4'h0) pulseViol++;
      prevErr = e;
    end else begin
      prevErr = 4'h0;
    end
  end

  function automatic logic [31:0] errVec();
    return {cntOvr[7:0], cntTo[7:0], cntLen[7:0], cntChk[7:0]};
  endfunction

  function automatic logic [31:0] errAdd(logic [31:0] base,
                                         logic [3:0] e);
    return base + {7'd0, e[3], 7'd0, e[2], 7'd0, e[1], 7'd0, e[0]};
  endfunction

  function automatic logic [7:0] vb(vec_t v, int i);
    return v.b[8*(v.n-1-i) +: 8];
  endfunction

  function automatic logic [7:0] chkOf(exp_t e);
    logic [7:0] c;
    c = e.len[7:0];
    for (int i = 0; i < e.len; i++) c ^= e.d[i];
    return c;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendByte(logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic readByte(int a, output logic [7:0] d);
    rd_addr = a[3:0];
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic verifyHeld(string nm, exp_t e);
    logic [7:0] d;
    check({nm, " len"}, 32'(frame_len), 32'(e.len));
    for (int i = 0; i < e.len; i++) begin
      readByte(i, d);
      check($sformatf("%s byte%0d", nm, i), 32'(d), 32'(e.d[i]));
    end
  endtask

  task automatic checkFrame(string nm);
    int w;
    exp_t e;
    w = 0;
    while (!frame_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({nm, " ready"}, 32'(frame_ready), 32'd1);
    if (sbQ.size() == 0) begin
      check({nm, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sbQ.pop_front();
      if (frame_ready) verifyHeld(nm, e);
    end
  endtask

  task automatic ackFrame(string nm);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    check({nm, " released"}, 32'(frame_ready), 32'd0);
  endtask

  task automatic sendFrame(exp_t e);
    sendByte(SOF_BYTE);
    sendByte(e.len[7:0]);
    for (int i = 0; i < e.len; i++) sendByte(e.d[i]);
    sendByte(chkOf(e));
  endtask

  initial begin
    logic [31:0] base;
    logic [7:0]  d;
    exp_t        e;

    vecs[0] = '{6, 160'hA50311223303,   1'b1, 3, 4'b0000};
    vecs[1] = '{5, 160'hA5021020FF,     1'b0, 0, 4'b0001};
    vecs[2] = '{4, 160'hA5015A5B,       1'b1, 1, 4'b0000};
    vecs[3] = '{2, 160'hA500,           1'b0, 0, 4'b0010};
    vecs[4] = '{2, 160'hA511,           1'b0, 0, 4'b0010};
    vecs[5] = '{6, 160'h42A502010201,   1'b1, 2, 4'b0000};
    vecs[6] = '{4, 160'hA5010000,       1'b0, 0, 4'b0001};
    vecs[7] = '{4, 160'hA501FFFE,       1'b1, 1, 4'b0000};

    idle(3);
    check("reset ready", 32'(frame_ready), 32'd0);
    check("reset len", 32'(frame_len), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'd0);
    check("reset errs",
          32'({err_overrun, err_timeout, err_len, err_chk}), 32'd0);
    rst = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      base = errVec();
      if (vecs[i].good) begin
        e.len = vecs[i].plen;
        for (int j = 0; j < 16; j++) e.d[j] = 8'h00;
        for (int j = 0; j < e.len; j++)
          e.d[j] = vb(vecs[i], vecs[i].n - 1 - e.len + j);
        sbQ.push_back(e);
      end
      for (int j = 0; j < vecs[i].n; j++) sendByte(vb(vecs[i], j));
      check($sformatf("vec%0d ready", i),
            32'(frame_ready), 32'(vecs[i].good));
      idle(2);
      check($sformatf("vec%0d errs", i),
            errVec(), errAdd(base, vecs[i].expErr));
      if (vecs[i].good) begin
        checkFrame($sformatf("vec%0d", i));
        ackFrame($sformatf("vec%0d", i));
      end
    end

    // maximum-length frame
    e.len = 16;
    for (int j = 0; j < 16; j++) e.d[j] = 8'(j * 17);
    sbQ.push_back(e);
    sendFrame(e);
    checkFrame("maxlen");
    ackFrame("maxlen");

    // overrun in HOLD, then ack and SOF in the same cycle
    e.len = 2;
    e.d[0] = 8'hC3;
    e.d[1] = 8'h3C;
    sendFrame(e);
    check("ovr held", 32'(frame_ready), 32'd1);
    base = errVec();
    sendByte(8'h77);
    idle(2);
    check("ovr pulse", errVec(), errAdd(base, 4'b1000));
    check("ovr still held", 32'(frame_ready), 32'd1);
    verifyHeld("ovr data", e);
    frame_ack = 1'b1;
    rx_data   = SOF_BYTE;
    rx_valid  = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    rx_valid  = 1'b0;
    check("ack+sof ready", 32'(frame_ready), 32'd0);
    e.len  = 1;
    e.d[0] = 8'h5A;
    sbQ.push_back(e);
    sendByte(8'h01);
    sendByte(8'h5A);
    sendByte(8'h5B);
    idle(1);
    check("ack+sof no ovr", errVec(), errAdd(base, 4'b1000));
    checkFrame("ack+sof");
    ackFrame("ack+sof");

    // inter-byte timeout boundary
    base = errVec();
    sendByte(SOF_BYTE);
    sendByte(8'h04);
    sendByte(8'h01);
    idle(TO - 10);
    check("to early", errVec(), base);
    idle(20);
    check("to pulse", errVec(), errAdd(base, 4'b0100));
    e.len  = 1;
    e.d[0] = 8'hAA;
    sbQ.push_back(e);
    sendFrame(e);
    checkFrame("after to");
    ackFrame("after to");

    // byte arriving exactly at expiry wins
    base = errVec();
    sendByte(SOF_BYTE);
    sendByte(8'h04);
    sendByte(8'h01);
    idle(TO - 1);
    e.len = 4;
    for (int j = 0; j < 4; j++) e.d[j] = 8'(j + 1);
    sbQ.push_back(e);
    sendByte(8'h02);
    sendByte(8'h03);
    sendByte(8'h04);
    sendByte(8'h00);
    check("to race errs", errVec(), base);
    checkFrame("to race");
    ackFrame("to race");

    // reset mid-frame
    sendByte(SOF_BYTE);
    sendByte(8'h03);
    sendByte(8'h11);
    rst = 1'b0;
    idle(2);
    check("midrst ready", 32'(frame_ready), 32'd0);
    check("midrst len", 32'(frame_len), 32'd0);
    check("midrst rd_data", 32'(rd_data), 32'd0);
    rst = 1'b1;
    idle(1);
    e.len  = 1;
    e.d[0] = 8'hAA;
    sbQ.push_back(e);
    sendFrame(e);
    checkFrame("after rst");
    readByte(0, d);
    check("after rst rd0", 32'(d), 32'hAA);
    ackFrame("after rst");

    idle(2);
    check("pulse shape", 32'(pulseViol), 32'd0);
    check("scoreboard drained", 32'(sbQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
